run_control: RTL and testbench

Parametrised machine-clock controller for the SAP core. It sits between the 1 kHz enable generator, the debounced front-panel controls and the core. It produces strictly paired `clken`/`clken_oop` enables in four modes (free-run at a programmable rate, single-step, N-step burst, hold) and latches the core's halt. Every issued `clken` is always followed by exactly one `clken_oop`, whatever happens to mode or halt mid-cycle.

---
 rtl/run_control.sv | 132 +++++++++++++
 tb/tb_run_control.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_control.sv
// Machine-clock controller for the SAP core: paired clken/clken_oop enables in
// auto, single-step, burst and hold modes, with a latched halt.
module run_control #(
    parameter int DIV_W  = 8,
    parameter int STEP_W = 8
) (
    input  logic              sysclk,
    input  logic              clear,
    input  logic              tick,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              step_req,
    input  logic              start,
    input  logic [STEP_W-1:0] burst_len,
    input  logic              halt,
    output logic              clken,
    output logic              clken_oop,
    output logic              running,
    output logic              halted,
    output logic [STEP_W-1:0] steps_left
);

    typedef enum logic [1:0] {STOP, RUN_A, RUN_B, HALTED} state_t;

    localparam logic [1:0] MODE_AUTO  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;

    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  cnt_next;
    logic [STEP_W-1:0] steps_next;
    logic              clken_next;
    logic              oop_next;
    logic              bursting;

    assign bursting = (steps_left != '0);

    always_ff @(posedge sysclk) begin
        if (clear) begin
            state      <= STOP;
            cnt        <= '0;
            steps_left <= '0;
            clken      <= 1'b0;
            clken_oop  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            steps_left <= steps_next;
            clken      <= clken_next;
            clken_oop  <= oop_next;
        end
    end

    assign running = (state == RUN_A) || (state == RUN_B);
    assign halted  = (state == HALTED);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        steps_next = steps_left;
        clken_next = 1'b0;
        oop_next   = 1'b0;
        case (state)
            STOP: begin
                if (halt) begin
                    state_next = HALTED;
                end else if (mode == MODE_AUTO) begin
                    state_next = RUN_A;
                    cnt_next   = rate_div;
                end else if (mode == MODE_STEP && step_req) begin
                    clken_next = 1'b1;
                    state_next = RUN_B;
                    cnt_next   = rate_div;
                end else if (mode == MODE_BURST && start && burst_len != '0) begin
                    clken_next = 1'b1;
                    state_next = RUN_B;
                    cnt_next   = rate_div;
                    steps_next = burst_len;
                end
            end
            RUN_A: begin
                if (halt) begin
                    state_next = HALTED;
                    steps_next = '0;
                end else if (!bursting && mode != MODE_AUTO) begin
                    state_next = STOP;
                end else if (tick) begin
                    if (cnt == '0) begin
                        clken_next = 1'b1;
                        state_next = RUN_B;
                        cnt_next   = rate_div;
                    end else begin
                        cnt_next = cnt - DIV_W'(1);
                    end
                end
            end
            RUN_B: begin
                // Once clken has gone out, nothing may stop its clken_oop partner.
                if (tick) begin
                    if (cnt == '0) begin
                        oop_next = 1'b1;
                        if (bursting) begin
                            steps_next = steps_left - STEP_W'(1);
                        end
                        if (halt) begin
                            state_next = HALTED;
                            steps_next = '0;
                        end else if (steps_left == STEP_W'(1)) begin
                            state_next = STOP;
                        end else if (bursting || mode == MODE_AUTO) begin
                            state_next = RUN_A;
                            cnt_next   = rate_div;
                        end else begin
                            state_next = STOP;
                        end
                    end else begin
                        cnt_next = cnt - DIV_W'(1);
                    end
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = STOP;
            end
        endcase
    end

endmodule

// File: tb/tb_run_control.sv
// Self-checking bench for run_control: a per-cycle behavioural model plus
// directed scenarios with hand-computed pulse positions.
module tb_run_control;

    logic       sysclk;
    logic       clear;
    logic       tick;
    logic [1:0] mode;
    logic [7:0] rate_div;
    logic       step_req;
    logic       start;
    logic [7:0] burst_len;
    logic       halt;
    logic       clken;
    logic       clken_oop;
    logic       running;
    logic       halted;
    logic [7:0] steps_left;

    int tests_run = 0;
    int failures  = 0;
    bit compare_on = 0;

    int tick_count = 0;
    int clk_count  = 0;
    int oop_count  = 0;
    int clk_ticks[$];
    int oop_ticks[$];
    int oop_steps[$];

    run_control #(.DIV_W(8), .STEP_W(8)) dut (
        .sysclk     (sysclk),
        .clear      (clear),
        .tick       (tick),
        .mode       (mode),
        .rate_div   (rate_div),
        .step_req   (step_req),
        .start      (start),
        .burst_len  (burst_len),
        .halt       (halt),
        .clken      (clken),
        .clken_oop  (clken_oop),
        .running    (running),
        .halted     (halted),
        .steps_left (steps_left)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Model: each half machine cycle lasts rate+1 ticks, counted upwards.
    localparam int P_IDLE = 0, P_WAIT_CLKEN = 1, P_WAIT_OOP = 2, P_HALT = 3;
    int m_phase  = P_IDLE;
    int m_ticks  = 0;
    int m_target = 1;
    int m_steps  = 0;
    int m_prior  = 0;
    bit exp_clken = 0;
    bit exp_oop   = 0;

    task automatic begin_half();
        m_ticks  = 0;
        m_target = int'(rate_div) + 1;
    endtask

    task automatic update_model();
        exp_clken = 0;
        exp_oop   = 0;
        if (clear) begin
            m_phase = P_IDLE;
            m_ticks = 0;
            m_steps = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (halt) m_phase = P_HALT;
                    else if (mode == 2'd0) begin
                        m_phase = P_WAIT_CLKEN;
                        begin_half();
                    end else if (mode == 2'd1 && step_req) begin
                        exp_clken = 1;
                        m_phase = P_WAIT_OOP;
                        begin_half();
                    end else if (mode == 2'd2 && start && burst_len != 0) begin
                        exp_clken = 1;
                        m_phase = P_WAIT_OOP;
                        m_steps = int'(burst_len);
                        begin_half();
                    end
                end
                P_WAIT_CLKEN: begin
                    if (halt) begin
                        m_phase = P_HALT;
                        m_steps = 0;
                    end else if (m_steps == 0 && mode != 2'd0) begin
                        m_phase = P_IDLE;
                    end else if (tick) begin
                        m_ticks++;
                        if (m_ticks == m_target) begin
                            exp_clken = 1;
                            m_phase = P_WAIT_OOP;
                            begin_half();
                        end
                    end
                end
                P_WAIT_OOP: begin
                    if (tick) begin
                        m_ticks++;
                        if (m_ticks == m_target) begin
                            exp_oop = 1;
                            m_prior = m_steps;
                            if (m_steps > 0) m_steps--;
                            if (halt) begin
                                m_phase = P_HALT;
                                m_steps = 0;
                            end else if (m_prior == 1) m_phase = P_IDLE;
                            else if (m_prior > 1 || mode == 2'd0) begin
                                m_phase = P_WAIT_CLKEN;
                                begin_half();
                            end else m_phase = P_IDLE;
                        end
                    end
                end
                default: m_phase = P_HALT;
            endcase
        end
    endtask

    always @(posedge sysclk) update_model();

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic compare_cycle();
        checkOutput("clken", 32'(clken), 32'(exp_clken));
        checkOutput("clken_oop", 32'(clken_oop), 32'(exp_oop));
        checkOutput("running", 32'(running), 32'(m_phase == P_WAIT_CLKEN || m_phase == P_WAIT_OOP));
        checkOutput("halted", 32'(halted), 32'(m_phase == P_HALT));
        checkOutput("steps_left", 32'(steps_left), 32'(m_steps));
    endtask

    task automatic record_pulses();
        if (clken === 1'b1) begin
            clk_count++;
            clk_ticks.push_back(tick_count);
        end
        if (clken_oop === 1'b1) begin
            oop_count++;
            oop_ticks.push_back(tick_count);
            oop_steps.push_back(int'(steps_left));
        end
    endtask

    always @(negedge sysclk) begin
        if (compare_on) begin
            compare_cycle();
            record_pulses();
        end
    end

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic applyStimulus(input logic t, input logic sr, input logic st);
        tick     = t;
        step_req = sr;
        start    = st;
        if (t) tick_count++;
        @(posedge sysclk);
        #2;
        tick     = 1'b0;
        step_req = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            for (int j = 1; j < gap; j++) applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic reset_counters();
        tick_count = 0;
        clk_count  = 0;
        oop_count  = 0;
        clk_ticks.delete();
        oop_ticks.delete();
        oop_steps.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end by 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clear = 1'b1; tick = 1'b0; mode = 2'b11; rate_div = 8'd2;
        step_req = 1'b0; start = 1'b0; burst_len = 8'd0; halt = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        compare_on = 1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset running", 32'(running), 0);
        checkOutput("reset steps_left", 32'(steps_left), 0);

        // Auto mode, rate_div=2, tick every 10 cycles
        clear = 1'b0; mode = 2'b00;
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset_counters();
        run_ticks(9, 10);
        checkOutput("auto clken count", 32'(clk_ticks.size()), 2);
        checkOutput("auto first clken tick", 32'(q_at(clk_ticks, 0)), 3);
        checkOutput("auto second clken tick", 32'(q_at(clk_ticks, 1)), 9);
        checkOutput("auto oop tick", 32'(q_at(oop_ticks, 0)), 6);
        checkOutput("auto running", 32'(running), 1);

        // Switch to hold while the clken_oop is pending
        mode = 2'b11;
        run_ticks(6, 10);
        checkOutput("hold oop count", 32'(oop_ticks.size()), 2);
        checkOutput("hold oop tick", 32'(q_at(oop_ticks, 1)), 12);
        checkOutput("hold no clken", 32'(clk_count), 2);
        checkOutput("hold running", 32'(running), 0);

        // Single step, second step_req in RUN_B ignored
        rate_div = 8'd0; mode = 2'b01;
        reset_counters();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("step clken latency", 32'(clken), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("step oop on tick", 32'(clken_oop), 1);
        run_ticks(3, 2);
        checkOutput("step clken count", 32'(clk_count), 1);
        checkOutput("step oop count", 32'(oop_count), 1);
        checkOutput("step running", 32'(running), 0);

        // Burst of 3 with rate_div=1
        rate_div = 8'd1; mode = 2'b10; burst_len = 8'd3;
        reset_counters();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("burst first clken", 32'(clken), 1);
        checkOutput("burst steps loaded", 32'(steps_left), 3);
        run_ticks(12, 3);
        checkOutput("burst clken count", 32'(clk_count), 3);
        checkOutput("burst oop count", 32'(oop_count), 3);
        checkOutput("burst steps at oop1", 32'(q_at(oop_steps, 0)), 2);
        checkOutput("burst steps at oop2", 32'(q_at(oop_steps, 1)), 1);
        checkOutput("burst steps at oop3", 32'(q_at(oop_steps, 2)), 0);
        checkOutput("burst end running", 32'(running), 0);
        burst_len = 8'd0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        run_ticks(2, 3);
        checkOutput("burst_len0 no pulse", 32'(clk_count), 3);

        // Halt raised one cycle after a clken in auto mode
        mode = 2'b00; rate_div = 8'd1;
        reset_counters();
        applyStimulus(1'b0, 1'b0, 1'b0);
        run_ticks(1, 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("halt pre clken", 32'(clken), 1);
        halt = 1'b1;
        run_ticks(4, 3);
        checkOutput("halt oop issued", 32'(oop_count), 1);
        checkOutput("halt halted", 32'(halted), 1);
        mode = 2'b01;
        applyStimulus(1'b1, 1'b1, 1'b0);
        mode = 2'b10; burst_len = 8'd3;
        applyStimulus(1'b1, 1'b0, 1'b1);
        mode = 2'b00; halt = 1'b0;
        run_ticks(3, 3);
        checkOutput("halted no clken", 32'(clk_count), 1);
        checkOutput("halted no oop", 32'(oop_count), 1);
        checkOutput("halted stays", 32'(halted), 1);
        clear = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("clear unhalts", 32'(halted), 0);

        // Clear in the same cycle as tick, step_req and halt
        clear = 1'b0; mode = 2'b00; rate_div = 8'd0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset_counters();
        clear = 1'b1; halt = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("clear wins halted", 32'(halted), 0);
        checkOutput("clear wins running", 32'(running), 0);
        checkOutput("clear wins clken", 32'(clken), 0);
        clear = 1'b0; halt = 1'b0; mode = 2'b11;
        run_ticks(3, 2);
        checkOutput("clear no pulse", 32'(clk_count + oop_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
